// File: rtl/jtag_types_pkg.sv
// Shared JTAG opcodes and DR select encoding
// for the TAP instruction/data register file.
package jtag_types_pkg;

   parameter int IR_W = 5;

   localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(1);
   localparam logic [IR_W-1:0] OP_USER    = IR_W'(2);
   localparam logic [IR_W-1:0] OP_BYPASS  = '1;
   localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

   typedef enum logic [1:0] {
      DR_BYPASS,
      DR_IDCODE,
      DR_USER
   } dr_sel_e;

endpackage

// File: rtl/jtag_shift_reg.sv
// Capture/shift/hold register: parallel-in,
// serial-in at MSB, LSB-out.
module jtag_shift_reg #(
   parameter int          W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         TCK,
   input  logic         TRST,
   input  logic         capture,
   input  logic         shift,
   input  logic         tdi,
   input  logic [W-1:0] pdata,
   output logic [W-1:0] q
);

   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST)
         q <= RST_VAL;
      else if (capture)
         q <= pdata;
      else if (shift)
         q <= W'({tdi, q} >> 1);
   end

endmodule

// File: rtl/tap_ir_dr.sv
// TAP instruction/data registers: IR, BYPASS,
// IDCODE and USER DR with negedge TDO.
module tap_ir_dr
   import jtag_types_pkg::*;
#(
   parameter int          IR_WIDTH   = 5,
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0FFF,
   parameter int          USER_W     = 32
) (
   input  logic                TCK,
   input  logic                TRST,
   input  logic                TDI,
   input  logic                tap_reset,
   input  logic                ir_capture,
   input  logic                ir_shift,
   input  logic                ir_update,
   input  logic                dr_capture,
   input  logic                dr_shift,
   input  logic                dr_update,
   input  logic [USER_W-1:0]   user_cap_data,
   output logic                TDO,
   output logic                tdo_en,
   output logic [IR_WIDTH-1:0] instr,
   output logic [USER_W-1:0]   user_upd_data,
   output logic                user_upd_pulse
);

   localparam logic [IR_WIDTH-1:0] I_IDCODE = IR_WIDTH'(OP_IDCODE);
   localparam logic [IR_WIDTH-1:0] I_USER   = IR_WIDTH'(OP_USER);
   localparam logic [IR_WIDTH-1:0] I_BYPASS = {IR_WIDTH{OP_BYPASS[0]}};
   localparam logic [IR_WIDTH-1:0] I_CAP    = IR_WIDTH'(IR_CAPTURE);

   logic [IR_WIDTH-1:0] ir_sr;
   logic [31:0]         idcode_sr;
   logic [USER_W-1:0]   user_sr;
   logic                bypass_sr;
   dr_sel_e             sel;
   logic                dr_so;
   logic                unused_id;

   assign unused_id = ^idcode_sr[31:1];

   always_comb begin
      sel = DR_BYPASS;
      unique case (1'b1)
         (instr == I_IDCODE): sel = DR_IDCODE;
         (instr == I_USER):   sel = DR_USER;
         (instr == I_BYPASS): sel = DR_BYPASS;
         default:             sel = DR_BYPASS;
      endcase
   end

   jtag_shift_reg #(.W(IR_WIDTH), .RST_VAL(I_CAP)) u_ir (
      .TCK     (TCK),
      .TRST    (TRST),
      .capture (ir_capture),
      .shift   (ir_shift),
      .tdi     (TDI),
      .pdata   (I_CAP),
      .q       (ir_sr)
   );

   jtag_shift_reg #(.W(32), .RST_VAL(IDCODE_VAL)) u_idcode (
      .TCK     (TCK),
      .TRST    (TRST),
      .capture (dr_capture && sel == DR_IDCODE),
      .shift   (dr_shift && sel == DR_IDCODE),
      .tdi     (TDI),
      .pdata   (IDCODE_VAL),
      .q       (idcode_sr)
   );

   jtag_shift_reg #(.W(USER_W), .RST_VAL('0)) u_user (
      .TCK     (TCK),
      .TRST    (TRST),
      .capture (dr_capture && sel == DR_USER),
      .shift   (dr_shift && sel == DR_USER),
      .tdi     (TDI),
      .pdata   (user_cap_data),
      .q       (user_sr)
   );

   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST)
         bypass_sr <= 1'b0;
      else if (dr_capture && sel == DR_BYPASS)
         bypass_sr <= 1'b0;
      else if (dr_shift && sel == DR_BYPASS)
         bypass_sr <= TDI;
   end

   always_comb begin
      dr_so = bypass_sr;
      unique case (sel)
         DR_IDCODE: dr_so = idcode_sr[0];
         DR_USER:   dr_so = user_sr[0];
         default:   dr_so = bypass_sr;
      endcase
   end

   // tap_reset outranks a coincident ir_update
   always_ff @(negedge TCK or negedge TRST) begin
      if (!TRST)
         instr <= I_IDCODE;
      else if (tap_reset)
         instr <= I_IDCODE;
      else if (ir_update)
         instr <= ir_sr;
   end

   always_ff @(negedge TCK or negedge TRST) begin
      if (!TRST) begin
         user_upd_data  <= '0;
         user_upd_pulse <= 1'b0;
      end else begin
         user_upd_pulse <= dr_update && instr == I_USER;
         if (dr_update && instr == I_USER)
            user_upd_data <= user_sr;
      end
   end

   always_ff @(negedge TCK or negedge TRST) begin
      if (!TRST) begin
         TDO    <= 1'b0;
         tdo_en <= 1'b0;
      end else begin
         tdo_en <= ir_shift | dr_shift;
         if (ir_shift)
            TDO <= ir_sr[0];
         else if (dr_shift)
            TDO <= dr_so;
      end
   end

endmodule

// File: tb/tb_tap_ir_dr.sv
// Self-checking bench for tap_ir_dr: scan-level
// reference model, vector table, random scans.
module tb_tap_ir_dr;

   localparam logic [31:0] IDV = 32'h1000_0FFF;

   localparam logic [6:0] S_TR = 7'b1000000;
   localparam logic [6:0] S_IC = 7'b0100000;
   localparam logic [6:0] S_IS = 7'b0010000;
   localparam logic [6:0] S_IU = 7'b0001000;
   localparam logic [6:0] S_DC = 7'b0000100;
   localparam logic [6:0] S_DS = 7'b0000010;
   localparam logic [6:0] S_DU = 7'b0000001;

   logic        TCK = 1'b0;
   logic        TRST = 1'b0;
   logic        TDI = 1'b0;
   logic        tap_reset = 1'b0;
   logic        ir_capture = 1'b0;
   logic        ir_shift = 1'b0;
   logic        ir_update = 1'b0;
   logic        dr_capture = 1'b0;
   logic        dr_shift = 1'b0;
   logic        dr_update = 1'b0;
   logic [31:0] user_cap_data = '0;
   logic        TDO;
   logic        tdo_en;
   logic [4:0]  instr;
   logic [31:0] user_upd_data;
   logic        user_upd_pulse;

   int passed = 0;
   int total = 0;

   logic [4:0]  m_instr = 5'd1;
   logic [31:0] m_upd = '0;

   tap_ir_dr #(
      .IR_WIDTH   (5),
      .IDCODE_VAL (IDV),
      .USER_W     (32)
   ) dut (
      .TCK            (TCK),
      .TRST           (TRST),
      .TDI            (TDI),
      .tap_reset      (tap_reset),
      .ir_capture     (ir_capture),
      .ir_shift       (ir_shift),
      .ir_update      (ir_update),
      .dr_capture     (dr_capture),
      .dr_shift       (dr_shift),
      .dr_update      (dr_update),
      .user_cap_data  (user_cap_data),
      .TDO            (TDO),
      .tdo_en         (tdo_en),
      .instr          (instr),
      .user_upd_data  (user_upd_data),
      .user_upd_pulse (user_upd_pulse)
   );

   always #5 TCK = ~TCK;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step(input logic [6:0] s, input logic d,
                       output logic o, output logic e, output logic p);
      @(posedge TCK);
      #1;
      {tap_reset, ir_capture, ir_shift, ir_update,
       dr_capture, dr_shift, dr_update} = s;
      TDI = d;
      @(negedge TCK);
      #1;
      o = TDO;
      e = tdo_en;
      p = user_upd_pulse;
   endtask

   task automatic ir_scan(input logic [4:0] op);
      logic o, e, p, en_ok;
      logic [4:0] q;
      en_ok = 1'b1;
      q = '0;
      step(S_IC, 1'b0, o, e, p);
      en_ok &= !e;
      for (int i = 0; i < 5; i++) begin
         step(S_IS, op[i], o, e, p);
         q[i] = o;
         en_ok &= e;
      end
      step(7'b0, 1'b0, o, e, p);
      en_ok &= !e;
      step(S_IU, 1'b0, o, e, p);
      en_ok &= !e;
      m_instr = op;
      check("ir_capture", 64'(q), 64'h1);
      check("ir_tdo_en", 64'(en_ok), 64'h1);
      check("instr", 64'(instr), 64'(m_instr));
   endtask

   // Expected TDO stream: the captured word for the DR length,
   // followed by the bits shifted in, delayed by that length.
   task automatic dr_scan(input int n, input logic [63:0] din,
                          input logic [31:0] cap,
                          output logic [63:0] dout);
      logic o, e, p, p2, en_ok, hold_ok;
      int len;
      logic [31:0] cv, upd;
      logic [63:0] exp;
      if (m_instr == 5'd1) begin
         len = 32;
         cv = IDV;
      end else if (m_instr == 5'd2) begin
         len = 32;
         cv = cap;
      end else begin
         len = 1;
         cv = '0;
      end
      exp = '0;
      for (int i = 0; i < n; i++)
         exp[i] = (i < len) ? cv[i] : din[i-len];
      for (int j = 0; j < 32; j++)
         upd[j] = (j + n < 32) ? cap[j+n] : din[j+n-32];
      dout = '0;
      en_ok = 1'b1;
      user_cap_data = cap;
      step(S_DC, 1'b0, o, e, p);
      en_ok &= !e;
      for (int i = 0; i < n; i++) begin
         step(S_DS, din[i], o, e, p);
         dout[i] = o;
         en_ok &= e;
      end
      step(7'b0, 1'b0, o, e, p);
      en_ok &= !e;
      hold_ok = (o === dout[n-1]);
      step(S_DU, 1'b0, o, e, p);
      step(7'b0, 1'b0, o, e, p2);
      if (m_instr == 5'd2)
         m_upd = upd;
      check("dr_tdo", dout, exp);
      check("dr_tdo_en", 64'(en_ok), 64'h1);
      check("tdo_hold", 64'(hold_ok), 64'h1);
      check("upd_pulse", 64'(p), 64'(m_instr == 5'd2));
      check("upd_pulse_end", 64'(p2), 64'h0);
      check("upd_data", 64'(user_upd_data), 64'(m_upd));
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [31:0] cap;
      logic [63:0] din;
      int          n;
      logic [63:0] exp;
   } vec_t;

   initial begin
      vec_t vt[4];
      logic o, e, p, pk;
      logic [63:0] dout;
      logic [4:0] op;

      vt[0] = '{5'd1, 32'h0, 64'h0, 32, 64'h1000_0FFF};
      vt[1] = '{5'd31, 32'h0, 64'b1101, 4, 64'b1010};
      vt[2] = '{5'd7, 32'h0, 64'b1101, 4, 64'b1010};
      vt[3] = '{5'd2, 32'hA5A5_0F0F, 64'h1234_5678, 32,
                64'hA5A5_0F0F};

      #12;
      check("rst_tdo", 64'(TDO), 64'h0);
      check("rst_tdo_en", 64'(tdo_en), 64'h0);
      check("rst_instr", 64'(instr), 64'h1);
      check("rst_upd_data", 64'(user_upd_data), 64'h0);
      check("rst_upd_pulse", 64'(user_upd_pulse), 64'h0);
      @(posedge TCK);
      #1;
      TRST = 1'b1;

      dr_scan(32, 64'h0, 32'h0, dout);
      check("rst_idcode", dout, 64'(IDV));

      for (int i = 0; i < 4; i++) begin
         ir_scan(vt[i].op);
         dr_scan(vt[i].n, vt[i].din, vt[i].cap, dout);
         check("vec_tdo", dout, vt[i].exp);
      end
      check("user_upd_const", 64'(user_upd_data), 64'h1234_5678);

      ir_scan(5'd2);
      step(S_TR, 1'b0, o, e, p);
      m_instr = 5'd1;
      check("tap_reset", 64'(instr), 64'h1);
      step(S_IU, 1'b0, o, e, p);
      check("ir_upd_after_tr", 64'(instr), 64'h2);
      step(S_TR | S_IU, 1'b0, o, e, p);
      check("tr_over_iu", 64'(instr), 64'h1);

      ir_scan(5'd2);
      user_cap_data = 32'hDEAD_BEEF;
      step(S_DC, 1'b0, o, e, p);
      for (int i = 0; i < 10; i++)
         step(S_DS, 1'b1, o, e, p);
      @(posedge TCK);
      #3;
      TRST = 1'b0;
      {tap_reset, ir_capture, ir_shift, ir_update,
       dr_capture, dr_shift, dr_update} = 7'b0;
      m_instr = 5'd1;
      m_upd = '0;
      #1;
      check("trst_instr", 64'(instr), 64'h1);
      check("trst_upd", 64'(user_upd_data), 64'h0);
      check("trst_en", 64'(tdo_en), 64'h0);
      check("trst_tdo", 64'(TDO), 64'h0);
      step(S_DU, 1'b0, o, e, p);
      pk = p;
      @(posedge TCK);
      #1;
      TRST = 1'b1;
      step(S_DU, 1'b0, o, e, p);
      pk |= p;
      step(7'b0, 1'b0, o, e, p);
      pk |= p;
      check("trst_no_pulse", 64'(pk), 64'h0);
      check("trst_upd_stay", 64'(user_upd_data), 64'h0);
      dr_scan(32, 64'h0, 32'h0, dout);

      for (int k = 0; k < 25; k++) begin
         if ($urandom_range(0, 4) == 0) begin
            step(S_TR, 1'b0, o, e, p);
            m_instr = 5'd1;
            check("rnd_tap_reset", 64'(instr), 64'h1);
         end else begin
            case ($urandom_range(0, 3))
               0: op = 5'd1;
               1: op = 5'd2;
               2: op = 5'd31;
               default: op = 5'($urandom);
            endcase
            ir_scan(op);
         end
         dr_scan($urandom_range(1, 40), {$urandom, $urandom},
                 $urandom, dout);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tap_ir_dr.md
# tap_ir_dr

Instruction and data register file driven by the TAP state decoder's strobes. Holds the IR shift and update stages, BYPASS, IDCODE and one USER data register. Selects the active DR from the current instruction and drives TDO/tdo_en on the falling edge of TCK. It sits directly downstream of the TAP controller and consumes its `tap_reset`, `ir_*` and `dr_*` strobes.

## Interface
Parameters:
- IR_WIDTH, 5, instruction register width (≥2)
- IDCODE_VAL, 32'h1000_0FFF, value captured by IDCODE DR (bit0 must be 1)
- USER_W, 32, USER data register width (≥1)

Ports:
- TCK  in  1  test clock
- TRST  in  1  reset, asynchronous, active-low
- TDI  in  1  serial data in
- tap_reset, ir_capture, ir_shift, ir_update, dr_capture, dr_shift, dr_update  in  1 each  TAP state strobes (high for the whole state)
- user_cap_data  in  USER_W  parallel value loaded into USER DR on capture
- TDO  out  1  serial data out
- tdo_en  out  1  TDO output enable
- instr  out  IR_WIDTH  current (updated) instruction
- user_upd_data  out  USER_W  USER DR update stage
- user_upd_pulse  out  1  one TCK period pulse after USER update

## Operation
- Opcodes: IDCODE = 'b0…01, USER = 'b0…10, BYPASS = all ones. Any other opcode selects BYPASS.
- IR shift stage (ir_sr):
  - posedge TCK with ir_capture: load 'b0…01.
  - posedge TCK with ir_shift: ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]}, LSB first.
- instr update:
  - negedge TCK with ir_update: instr <= ir_sr.
  - negedge TCK with tap_reset: instr <= IDCODE. tap_reset wins over ir_update.
- DR selection by instr:
  - IDCODE → 32-bit idcode_sr.
  - USER → USER_W-bit user_sr.
  - else → 1-bit bypass_sr.
- DR capture and shift (posedge TCK, selected register only; unselected registers hold):
  - dr_capture: idcode_sr <= IDCODE_VAL; user_sr <= user_cap_data; bypass_sr <= 0.
  - dr_shift: right shift with TDI into the MSB.
- USER update: negedge TCK with dr_update and instr == USER → user_upd_data <= user_sr, user_upd_pulse <= 1. At every other negedge, user_upd_pulse <= 0.
- TDO mux (registered at negedge):
  - ir_shift → ir_sr[0].
  - dr_shift → selected DR [0].
  - else → hold previous value.
- tdo_en <= ir_shift | dr_shift (registered at negedge).
- Simultaneous ir_shift and dr_shift cannot come from the TAP. If both are asserted, IR has priority.

## Timing
- Reset (TRST low, asynchronous), all outputs and registers take these values:
  - instr = IDCODE, ir_sr = 'b0…01.
  - idcode_sr = IDCODE_VAL, user_sr = 0, bypass_sr = 0.
  - user_upd_data = 0, user_upd_pulse = 0, TDO = 0, tdo_en = 0.
- TRST asserted mid-shift: all shift contents are lost, instr returns to IDCODE, and no update pulse is generated.
- Capture value appears on TDO at the negedge in the first SHIFT state cycle, i.e. half a TCK after entering SHIFT. Each later negedge presents the next bit.
- TDI is sampled on posedge. An N-bit register plus the TDO register gives a TDI→TDO latency of N TCK cycles, e.g. 1 cycle for BYPASS.
- New instr takes effect from the negedge in UPDATE_IR. It governs the next DR capture.
- user_upd_pulse is high from the UPDATE_DR negedge to the next negedge.

## Structure
- jtag_types_pkg: opcode localparams (OP_IDCODE, OP_USER, OP_BYPASS, sized to IR_WIDTH via a package parameter default of 5) and IR_CAPTURE constant.
- Sub-module jtag_shift_reg #(W): capture/shift/hold register with parallel-in, serial-in, LSB-out. It is instantiated for the IR, IDCODE and USER registers. BYPASS stays inline.
- Top: instr update logic, DR select decode, TDO/tdo_en negedge registers.

## Test plan
- Reset: pulse TRST low, then 32 DR shift cycles with TDI=0 → TDO bit sequence equals 32'h1000_0FFF, LSB first; tdo_en high only during shift.
- IR capture: enter SHIFT_IR, shift 5 bits → TDO returns 1,0,0,0,0.
- BYPASS: load IR 'b11111, shift DR pattern 1,0,1,1 → TDO emits 0 (captured), then 1,0,1 delayed by one cycle.
- Unknown opcode 'b00111 → behaves as BYPASS (1-cycle delay, captured 0).
- USER: load IR 'b00010, user_cap_data=32'hA5A5_0F0F, shift in 32'h1234_5678 → TDO emits A5A5_0F0F LSB first. After UPDATE_DR, user_upd_data=32'h1234_5678 and user_upd_pulse is high for exactly one TCK.
- tap_reset and mid-shift TRST: with instr=USER, assert tap_reset → instr=IDCODE at the next negedge. Drop TRST during USER DR shift → user_upd_pulse never asserts and user_upd_data stays 0.
